// File: rtl/linecard_fifo_scheduler_pkg.sv
// Shared line-card definitions: port count, FIFO pointer types and the
// scheduler state encoding.
package LineCardPkg;

    localparam int LINECARD_PORTS = 24;
    localparam int FIFO_PTR_BITS  = 13;
    // A FIFO holds 4096 words; any larger occupancy means broken pointers.
    localparam int FIFO_DEPTH     = 4096;

    typedef logic [FIFO_PTR_BITS-1:0] fifo_ptr_t;
    typedef logic [4:0]               port_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        BUSY,
        HOLDOFF
    } sched_state_t;

endpackage

// File: rtl/linecard_fifo_scheduler_round_robin_picker.sv
// Combinational round-robin picker: the first requester after last_grant,
// wrapping from NUM_REQ-1 back to 0. Shared with the egress schedulers.
module round_robin_picker #(
    parameter int NUM_REQ = 24,
    parameter int IDX_W   = 5
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [IDX_W-1:0] upper_idx;
    logic             upper_found;
    logic [IDX_W-1:0] lower_idx;
    logic             lower_found;

    // Lowest requester above last_grant wins; otherwise the lowest overall.
    always_comb begin
        upper_idx   = '0;
        upper_found = 1'b0;
        lower_idx   = '0;
        lower_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lower_idx   = IDX_W'(i);
                lower_found = 1'b1;
                if (i > int'(last_grant)) begin
                    upper_idx   = IDX_W'(i);
                    upper_found = 1'b1;
                end
            end
        end
        winner = upper_found ? upper_idx : lower_idx;
        found  = lower_found;
    end

endmodule

// File: rtl/linecard_fifo_scheduler.sv
// Line-card FIFO scheduler: grants the shared URAM read port to one ingress
// FIFO per frame, round-robin, with safe retraction on per-port resets.
module linecard_fifo_scheduler
    import LineCardPkg::*;
#(
    parameter int NUM_PORTS      = LINECARD_PORTS,
    parameter int PTR_BITS       = FIFO_PTR_BITS,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [PTR_BITS-1:0]  wr_ptr_committed [NUM_PORTS],
    input  logic [PTR_BITS-1:0]  rd_ptr           [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] rd_ptr_reset,
    output logic                 grant_valid,
    output port_idx_t            grant_port,
    output logic [PTR_BITS-1:0]  grant_words,
    input  logic                 grant_ready,
    input  logic                 frame_done,
    output logic                 frame_abort,
    output logic [NUM_PORTS-1:0] port_pending,
    output logic                 err_overflow,
    output port_idx_t            err_port
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [PTR_BITS-1:0] OVF_LIMIT = PTR_BITS'(FIFO_DEPTH);

    logic [PTR_BITS-1:0]  occ_next [NUM_PORTS];
    logic [PTR_BITS-1:0]  occ_reg  [NUM_PORTS];
    logic [NUM_PORTS-1:0] pending_reg;

    sched_state_t         state_reg, state_next;
    port_idx_t            grant_port_reg, last_grant_reg, pick_winner, ovf_idx;
    logic [PTR_BITS-1:0]  grant_words_reg;
    logic [CNT_W-1:0]     hold_cnt_reg;
    logic                 frame_abort_reg, err_overflow_reg, pick_found, ovf_any;
    port_idx_t            err_port_reg;
    logic                 granted_reset;

    // Modulo subtraction handles the wrap bit for free.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_occ
            assign occ_next[gi] = wr_ptr_committed[gi] - rd_ptr[gi];
        end
    endgenerate

    // Occupancy and request mask registered once per cycle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_PORTS; i++) occ_reg[i] <= '0;
            pending_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                occ_reg[i]     <= occ_next[i];
                pending_reg[i] <= (occ_next[i] != '0) && !rd_ptr_reset[i];
            end
        end
    end

    // Lowest port whose occupancy exceeds the FIFO depth.
    always_comb begin
        ovf_any = 1'b0;
        ovf_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (occ_reg[i] > OVF_LIMIT) begin
                ovf_any = 1'b1;
                ovf_idx = port_idx_t'(i);
            end
        end
    end

    // Sticky overflow flag; the first offending port is kept.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            err_overflow_reg <= 1'b0;
            err_port_reg     <= '0;
        end else if (!err_overflow_reg && ovf_any) begin
            err_overflow_reg <= 1'b1;
            err_port_reg     <= ovf_idx;
        end
    end

    round_robin_picker #(
        .NUM_REQ (NUM_PORTS),
        .IDX_W   (5)
    ) u_picker (
        .req        (pending_reg),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .found      (pick_found)
    );

    assign granted_reset = rd_ptr_reset[grant_port_reg];

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; a reset of the granted port beats ready and frame_done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = OFFER;
            OFFER: begin
                if (granted_reset)    state_next = IDLE;
                else if (grant_ready) state_next = BUSY;
            end
            BUSY: begin
                if (granted_reset || frame_done)
                    state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: if (hold_cnt_reg == HOLD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant snapshot, round-robin pointer, holdoff counter and abort strobe.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grant_port_reg  <= '0;
            grant_words_reg <= '0;
            last_grant_reg  <= port_idx_t'(NUM_PORTS - 1);
            hold_cnt_reg    <= '0;
            frame_abort_reg <= 1'b0;
        end else begin
            frame_abort_reg <= (state_reg == BUSY) && granted_reset;
            if (state_reg == IDLE && pick_found) begin
                grant_port_reg  <= pick_winner;
                grant_words_reg <= occ_reg[pick_winner];
                last_grant_reg  <= pick_winner;
            end
            if (state_reg == HOLDOFF) hold_cnt_reg <= hold_cnt_reg + 1'b1;
            else                      hold_cnt_reg <= '0;
        end
    end

    // Outputs.
    always_comb begin
        grant_valid  = (state_reg == OFFER);
        grant_port   = grant_port_reg;
        grant_words  = grant_words_reg;
        frame_abort  = frame_abort_reg;
        port_pending = pending_reg;
        err_overflow = err_overflow_reg;
        err_port     = err_port_reg;
    end

endmodule
